capture_reg_bank: RTL

Parametrised successor to the single-entry count register. Samples a WIDTH-bit `count` input every clock while `status` is low and keeps a DEPTH-entry circular history of past samples. The newest sample is on `register` and any older entry is readable by age index. Sits beside the counter datapath as a debug and trace capture point; `status` high freezes the history for inspection.

---
 rtl/capture_reg_bank.sv | 86 ++++++++
 1 files changed

// File: rtl/capture_reg_bank.sv
// rtl/capture_reg_bank.sv - DEPTH-entry circular capture history of a WIDTH-bit count sample.
// Optional macro CAPTURE_CHANGE_ONLY_EN: record only samples that differ from the newest entry.
module capture_reg_bank #(
    parameter  int WIDTH = 2,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             status,
    input  logic             clear,
    input  logic [WIDTH-1:0] count,
    input  logic [AW-1:0]    rd_idx,
    output logic [WIDTH-1:0] register,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      fill,
    output logic             full,
    output logic             frozen
);

    localparam logic [0:0]  S_CAPTURE = 1'b0;
    localparam logic [0:0]  S_HOLD    = 1'b1;
    localparam logic [AW:0] FILL_MAX  = (AW+1)'(DEPTH);

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_fill;
    logic [WIDTH-1:0] r_register;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_capture;
    logic [AW-1:0]    w_rd_addr;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_CAPTURE: if (status)  w_next_state = S_HOLD;
            S_HOLD:    if (!status) w_next_state = S_CAPTURE;
            default:                w_next_state = S_CAPTURE;
        endcase
    end

`ifdef CAPTURE_CHANGE_ONLY_EN
    // An empty history always accepts, so the first sample after clear/reset is kept.
    assign w_capture = !clear && !status && ((count != r_register) || (r_fill == '0));
`else
    assign w_capture = !clear && !status;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_CAPTURE;
            r_wr_ptr   <= '0;
            r_fill     <= '0;
            r_register <= '0;
        end else begin
            r_state <= w_next_state;
            if (clear) begin
                r_wr_ptr   <= '0;
                r_fill     <= '0;
                r_register <= '0;
            end else if (w_capture) begin
                r_wr_ptr   <= r_wr_ptr + AW'(1);
                r_register <= count;
                if (r_fill != FILL_MAX) begin
                    r_fill <= r_fill + (AW+1)'(1);
                end
            end
        end
    end

    // Storage needs no reset: entries beyond fill are masked on the read side.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem[r_wr_ptr] <= count;
        end
    end

    assign w_rd_addr = r_wr_ptr - AW'(1) - rd_idx;
    assign rd_data   = ({1'b0, rd_idx} < r_fill) ? r_mem[w_rd_addr] : '0;
    assign register  = r_register;
    assign fill      = r_fill;
    assign full      = (r_fill == FILL_MAX);
    assign frozen    = r_state;

endmodule
